// File: rtl/gate_tt_pkg.sv
// Shared types and helpers for the truth-table sequencer and its settle timer.
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned N_IN_MAX = 4;

  function automatic int unsigned nvec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic logic exp_bit(input logic [(1 << N_IN_MAX)-1:0] mask,
                                   input logic [N_IN_MAX-1:0] idx);
    return mask[idx];
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; zero flags the cycle on which the held vector is sampled.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks every input combination of a gate under test and checks it against a truth-table mask.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned                 N_IN   = 2,
  parameter int unsigned                 SETTLE = 1,
  parameter logic [(1 << N_IN)-1:0]      EXPECT = 4'b1110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int unsigned     NVEC = nvec(N_IN);
  localparam logic [N_IN-1:0] LAST = N_IN'(NVEC - 1);

  state_t          state;
  logic            zero;
  logic            load;
  logic            mismatch;
  logic [N_IN:0]   err_next;
  logic            cap_vld;
  logic [N_IN-1:0] cap_idx;
  logic            cap_vld_next;
  logic [N_IN-1:0] cap_idx_next;

  assign load = ((state == IDLE || state == DONE) && start) ||
                (state == APPLY && zero && vec != LAST);

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (4'(SETTLE)),
    .zero     (zero)
  );

  // First-failure capture runs internally; the ports only expose it once done so they read 0 while busy.
  always_comb begin
    mismatch     = (dut_y != exp_bit(16'(EXPECT), 4'(vec)));
    err_next     = err_cnt + (N_IN+1)'(mismatch);
    cap_vld_next = cap_vld;
    cap_idx_next = cap_idx;
    if (mismatch && !cap_vld) begin
      cap_vld_next = 1'b1;
      cap_idx_next = vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      cap_vld        <= 1'b0;
      cap_idx        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= APPLY;
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            cap_vld        <= 1'b0;
            cap_idx        <= '0;
          end
        end
        APPLY: begin
          if (zero) begin
            err_cnt <= err_next;
            cap_vld <= cap_vld_next;
            cap_idx <= cap_idx_next;
            if (vec == LAST) begin
              state          <= DONE;
              busy           <= 1'b0;
              done           <= 1'b1;
              pass           <= (err_next == '0);
              first_fail_vld <= cap_vld_next;
              first_fail_idx <= cap_idx_next;
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
Self-checking truth-table engine that wraps a combinational gate under test, such as the NAND-built OR.
- Upstream role: drives every input combination onto the gate inputs in ascending order.
- Downstream role: samples the gate output after a settle window and compares it against an expected truth-table mask.
- Reports mismatch count, first failing vector and a pass flag, replacing hand-stepped display benches with a synthesizable checker.

Parameters:
- N_IN, 2, number of gate inputs (1..4).
- SETTLE, 1, extra cycles each vector is held before sampling (0..15).
- EXPECT, 4'b1110, expected output per vector index; width 2**N_IN; bit i = expected y for vec==i (default = 2-input OR).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle run request.
- vec  output  N_IN  stimulus to gate under test; vec[0]=a, vec[1]=b, ...
- dut_y  input  1  gate-under-test output.
- busy  output  1  run in progress.
- done  output  1  run complete; held until restart or reset.
- pass  output  1  valid when done; 1 iff err_cnt==0.
- err_cnt  output  N_IN+1  number of mismatching vectors.
- first_fail_vld  output  1  at least one mismatch captured.
- first_fail_idx  output  N_IN  index of first mismatching vector.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port rst.
- Reset values: all outputs 0; state IDLE; settle counter 0.
- States: IDLE, APPLY, DONE.
- IDLE:
  - start=1 at an edge -> APPLY.
  - At the same edge: vec<=0, settle counter<=SETTLE, err_cnt<=0, first_fail_vld<=0, first_fail_idx<=0, busy<=1.
- APPLY:
  - vec is held constant for SETTLE+1 cycles.
  - Settle counter >0: decrement.
  - Settle counter ==0: sample dut_y at that edge and compare with EXPECT[vec].
    - On mismatch: err_cnt+1. If first_fail_vld==0, capture first_fail_idx<=vec and set first_fail_vld<=1.
    - If vec==2**N_IN-1: go to DONE; busy<=0, done<=1, pass<=(final err_cnt==0), with the current mismatch included.
    - Otherwise: vec<=vec+1, reload settle counter with SETTLE.
- DONE:
  - vec holds the last index; all results are held.
  - start=1 -> behaves as start from IDLE: clears results, done<=0, pass<=0, busy<=1, vec<=0.
- Latency: done rises 2**N_IN*(SETTLE+1) edges after the edge that accepted start. With defaults, 8 cycles.
- start while busy is ignored; no queuing.
- rst mid-run: next edge returns to reset values (vec=0, busy=0, done=0); any partial results are discarded.
- rst and start in the same cycle: rst wins.
- Width rules:
  - err_cnt maximum is 2**N_IN, which fits N_IN+1 bits; no saturation needed.
  - vec never wraps: the terminal index exits to DONE.
- SETTLE=0:
  - One cycle per vector.
  - dut_y must be combinational from vec within the same cycle.
- pass and first_fail_* are only meaningful while done=1; they are 0 while busy.

Decomposition:
- Package gate_tt_pkg:
  - state enum (IDLE, APPLY, DONE).
  - localparam NVEC = 2**N_IN helper.
  - function exp_bit(mask, idx) returning the expected output bit.
- One sub-module, tt_settle_timer:
  - Loadable down-counter with zero flag.
  - Ports: clk, rst, load, load_val, zero.
- The FSM, compare logic and result registers stay in the top module.

Test Plan:
1. Default params, dut_y=vec[0]|vec[1], pulse start -> vec sequence 0,0,1,1,2,2,3,3; done=1 exactly 8 cycles after start; pass=1; err_cnt=0; first_fail_vld=0.
2. dut_y tied 0, OR mask -> err_cnt=3, first_fail_vld=1, first_fail_idx=1, pass=0.
3. dut_y=vec[0]&vec[1] (AND) against OR mask -> mismatches at 1 and 2; err_cnt=2, first_fail_idx=1, pass=0.
4. start re-pulsed at cycle 3 of a run -> ignored; done still at cycle 8; results as in scenario 1. Then start in DONE -> done drops next edge and a full rerun gives identical results.
5. rst asserted while vec=2 -> next edge vec=0, busy=0, done=0, err_cnt=0; start afterwards runs cleanly to pass=1.
6. SETTLE=0, EXPECT=4'b0111, dut_y=~(vec[0]&vec[1]) (NAND) -> vec changes every cycle; done 4 cycles after start; pass=1.
